// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor I/O responder.
// Holds the ADDR[15:12] page map, timer register offsets and timer state encoding.
package proc_io_pkg;

  // ADDR[15:12] page map
  localparam logic [3:0] IO_LEDR  = 4'h1;
  localparam logic [3:0] IO_HEX   = 4'h2;
  localparam logic [3:0] IO_SW    = 4'h3;
  localparam logic [3:0] IO_TIMER = 4'h4;

  // Timer register select on ADDR[0]
  localparam logic TMR_COUNT_OFF = 1'b0;
  localparam logic TMR_STAT_OFF  = 1'b1;

  // Seven-segment digits HEX0..HEX5; digit indices 6/7 are unmapped
  localparam int unsigned NUM_HEX    = 6;
  localparam logic [2:0]  HEX_DIGITS = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } tmr_state_e;

endpackage

// File: rtl/io_timer.sv
// Programmable down-timer: a prescaler divides the clock into ticks, and each tick
// decrements the loaded count. Reaching zero latches the done flag.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_we_i, load_val_i  write to the count register (0 aborts / is ignored)
//   clear_we_i           write to the status register (acknowledges done)
//   count_o              remaining count
//   running_o, done_o    status flags; done_o doubles as the interrupt
module io_timer
  import proc_io_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned TIMER_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_we_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               clear_we_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               running_o,
  output logic               done_o
);

  localparam int unsigned    PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  tmr_state_e         state_q, state_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic               load_nz;

  assign load_nz = load_we_i && (load_val_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    unique case (state_q)
      StIdle: begin
        if (load_nz) begin
          state_d = StRun;
          count_d = load_val_i;
          pre_d   = '0;
        end
      end
      StRun: begin
        // A write always beats the tick on the same edge
        if (load_nz) begin
          count_d = load_val_i;
          pre_d   = '0;
        end else if (load_we_i) begin
          state_d = StIdle;
          count_d = '0;
          pre_d   = '0;
        end else if (pre_q == PreLast) begin
          pre_d   = '0;
          count_d = count_q - TIMER_W'(1);
          if (count_q == TIMER_W'(1)) state_d = StDone;
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end
      StDone: begin
        if (load_nz) begin
          state_d = StRun;
          count_d = load_val_i;
          pre_d   = '0;
        end else if (clear_we_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign count_o   = count_q;
  assign running_o = (state_q == StRun);
  assign done_o    = (state_q == StDone);

endmodule

// File: rtl/proc_io_responder.sv
// Memory-mapped I/O responder on the 16-bit processor bus.
// Decodes ADDR[15:12] into LEDR, HEX0..HEX5, SW and timer pages; writes land on the
// strobe edge, reads return registered data one cycle after the address.
// Ports:
//   Clock, Resetn       clock, asynchronous active-low reset
//   ADDR, DOUT, W       processor address, write data, write strobe
//   SW                  raw switches (asynchronous, synchronised here)
//   DIN                 registered read data
//   LEDR, HEX0..HEX5    LED register and active-low segment outputs
//   TIRQ                timer done flag
module proc_io_responder
  import proc_io_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned TIMER_W  = 16
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic [9:0]  SW,
  output logic [15:0] DIN,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        TIRQ
);

  logic [3:0]         page;
  logic [2:0]         hex_digit;
  logic               we_ledr, we_hex, tmr_load, tmr_clear;
  logic [9:0]         ledr_q;
  logic [6:0]         hex_q [NUM_HEX];
  logic [9:0]         sw_meta_q, sw_sync_q;
  logic [15:0]        din_q, rdata;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_running, tmr_done;
  logic               unused_bits;

  assign page      = ADDR[15:12];
  assign hex_digit = ADDR[2:0];
  assign unused_bits = ^{ADDR[11:3], DOUT};

  assign we_ledr   = W && (page == IO_LEDR);
  assign we_hex    = W && (page == IO_HEX) && (hex_digit < HEX_DIGITS);
  assign tmr_load  = W && (page == IO_TIMER) && (ADDR[0] == TMR_COUNT_OFF);
  assign tmr_clear = W && (page == IO_TIMER) && (ADDR[0] == TMR_STAT_OFF);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ledr_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      din_q     <= '0;
      for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= '0;
    end else begin
      if (we_ledr) ledr_q <= DOUT[9:0];
      if (we_hex) hex_q[hex_digit] <= DOUT[6:0];
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      // Registered every cycle so reads line up with synchronous memory
      din_q     <= rdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (page)
      IO_LEDR:  rdata = 16'(ledr_q);
      IO_HEX:   if (hex_digit < HEX_DIGITS) rdata = 16'(hex_q[hex_digit]);
      IO_SW:    rdata = 16'(sw_sync_q);
      IO_TIMER: rdata = (ADDR[0] == TMR_STAT_OFF) ? {14'b0, tmr_running, tmr_done}
                                                  : 16'(tmr_count);
      default:  rdata = '0;
    endcase
  end

  io_timer #(
    .PRESCALE (PRESCALE),
    .TIMER_W  (TIMER_W)
  ) u_timer (
    .clk_i      (Clock),
    .rst_ni     (Resetn),
    .load_we_i  (tmr_load),
    .load_val_i (DOUT[TIMER_W-1:0]),
    .clear_we_i (tmr_clear),
    .count_o    (tmr_count),
    .running_o  (tmr_running),
    .done_o     (tmr_done)
  );

  assign DIN  = din_q;
  assign LEDR = ledr_q;
  assign TIRQ = tmr_done;
  assign HEX0 = ~hex_q[0];
  assign HEX1 = ~hex_q[1];
  assign HEX2 = ~hex_q[2];
  assign HEX3 = ~hex_q[3];
  assign HEX4 = ~hex_q[4];
  assign HEX5 = ~hex_q[5];

endmodule

// File: doc/proc_io_responder.md
Name: proc_io_responder

Overview:
- Memory-mapped I/O responder on the processor's 16-bit bus, serving the processor's load/store traffic.
- Captures writes to the LEDR and HEX0..HEX5 registers.
- Returns synchronised SW values, a programmable down-timer count and its status on reads.
- Instantiated in part5 beside the instruction/data memory; the top level muxes its DIN with memory DIN on ADDR[15:12].

Parameters:
- PRESCALE, 50000, Clock cycles per timer tick (1 ms at 50 MHz; benches use 4).
- TIMER_W, 16, timer counter width; must not exceed 16.

Ports:
- Clock  in  1  system clock; all state rises on posedge.
- Resetn  in  1  asynchronous, active-low reset (KEY[0] at top).
- ADDR  in  16  processor address.
- DOUT  in  16  processor write data.
- W  in  1  write strobe, one cycle per store.
- SW  in  10  raw board switches (asynchronous).
- DIN  out  16  read data, registered.
- LEDR  out  10  LED register.
- HEX0..HEX5  out  7 each  segment outputs, active-low.
- TIRQ  out  1  timer done flag.

Behaviour:
- Reset value of every output and internal register is 0: LEDR=0, DIN=0, TIRQ=0, timer idle, prescaler 0, SW synchroniser 0.
- HEX outputs are ~hexreg, so HEXn=7'h7F (blank) during and after reset.
- Decode on ADDR[15:12]:
  - 4'h1 LEDR
  - 4'h2 HEX; digit = ADDR[2:0], 0..5 valid, 6/7 ignored
  - 4'h3 SW, read-only
  - 4'h4 timer; ADDR[0]=0 count reg, ADDR[0]=1 status
  - any other value: not selected; writes ignored, DIN=0
- Write: when W=1 and decode hits, the register updates on the same posedge.
  - LEDR <= DOUT[9:0]; hexreg[d] <= DOUT[6:0]; upper bits discarded.
- Read latency is one cycle: DIN at cycle n+1 reflects ADDR at cycle n, registered every cycle regardless of W (same timing as synchronous memory).
  - SW read: {6'b0, sw_sync}.
  - Count read: zero-extended remaining count.
  - Status read: {14'b0, running, done}.
  - LEDR/HEX are readable back at their write addresses, zero-extended.
- SW passes a 2-flop synchroniser; a SW change is visible in DIN no earlier than 3 cycles later.
- Timer FSM states are IDLE, RUN, DONE:
  - IDLE: a write to 0x4000 with DOUT!=0 loads count=DOUT[TIMER_W-1:0], clears prescaler, goes to RUN. A write of 0 is ignored (stays IDLE).
  - RUN: prescaler counts 0..PRESCALE-1. At wrap, count decrements; the decrement that reaches 0 goes to DONE, TIRQ=1.
  - RUN with a write to 0x4000: reload count and prescaler (restart). Writing 0 aborts to IDLE with no TIRQ.
  - DONE: TIRQ held until any write to 0x4001 (→IDLE, TIRQ=0) or a write to 0x4000 with DOUT!=0 (→RUN, TIRQ=0 same edge).
- Simultaneous events: a clear write to 0x4001 on the same edge as terminal count → terminal count wins; DONE, TIRQ=1.
- Mid-operation reset: all state returns to reset values immediately (asynchronous); an active timer and pending TIRQ are lost.
- W=1 to an unmapped address has no side effects.

Decomposition:
- Shared package proc_io_pkg:
  - page constants IO_LEDR=4'h1, IO_HEX=4'h2, IO_SW=4'h3, IO_TIMER=4'h4
  - TMR_COUNT_OFF=0, TMR_STAT_OFF=1
  - timer state encoding {IDLE, RUN, DONE}
- One sub-module: io_timer (prescaler + down-counter + FSM, TIRQ, count/status outputs). Decode, registers and the read mux stay in proc_io_responder.

Test Plan:
- Reset then idle → HEX0..5=7'h7F, LEDR=0, DIN=0, TIRQ=0; reassert Resetn mid-run → same values without waiting for a clock.
- Write 0x1000←16'hFFFF, then read 0x1000 → LEDR=10'h3FF; DIN=16'h03FF one cycle after the address.
- Write 0x2003←16'h0040, 0x2006←16'h007F → HEX3=7'h3F, all other HEX remain 7'h7F.
- SW=10'b1000000000, read 0x3000 from cycle 3 onward → DIN=16'h0200.
- PRESCALE=4: write 0x4000←3 → TIRQ rises exactly 12 cycles after the write edge; status read=16'h0001; write 0x4001 → TIRQ=0, status=0.
- PRESCALE=4: write 0x4000←5, then after 6 cycles write 0x4000←0 → state IDLE, TIRQ never asserts; count read=0.
